mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_ctrl_pkg.sv | 18 +
 rtl/mem_stage_ctrl_branch.sv | 42 ++++
 rtl/mem_stage_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM stage controller: FSM state encoding,
// PCSel codes and the default memory-timeout length.
package mem_stage_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ABORT    = 2'd2
   } state_e;

   localparam logic [1:0] PCSEL_SEQ    = 2'd0;
   localparam logic [1:0] PCSEL_BRANCH = 2'd1;
   localparam logic [1:0] PCSEL_JUMP   = 2'd2;
   localparam logic [1:0] PCSEL_REG    = 2'd3;

   localparam int TIMEOUT_CYCLES_DEFAULT = 15;

endpackage

// File: rtl/mem_stage_ctrl_branch.sv
// branch_resolve: combinational redirect resolution for the MEM stage.
// Priority is JR, then J/JAL, then a taken conditional branch.
module branch_resolve
   import mem_stage_ctrl_pkg::*;
(
   input  logic        beq,
   input  logic        bne,
   input  logic        zero,
   input  logic        j,
   input  logic        jal,
   input  logic        jr,
   input  logic [31:0] branch_address,
   input  logic [31:0] jump_address,
   input  logic [31:0] read_data1,
   output logic        taken,
   output logic        redirect,
   output logic [1:0]  pc_sel,
   output logic [31:0] next_pc
);

   assign taken = (beq & zero) | (bne & ~zero);

   always_comb begin
      pc_sel   = PCSEL_SEQ;
      next_pc  = 32'd0;
      redirect = 1'b0;
      if (jr) begin
         pc_sel   = PCSEL_REG;
         next_pc  = read_data1;
         redirect = 1'b1;
      end else if (j | jal) begin
         pc_sel   = PCSEL_JUMP;
         next_pc  = jump_address;
         redirect = 1'b1;
      end else if (taken) begin
         pc_sel   = PCSEL_BRANCH;
         next_pc  = branch_address;
         redirect = 1'b1;
      end
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: redirect/flush, data-memory handshake and stalls.
// Define MEM_TIMEOUT_EN to abort accesses whose mem_ready never arrives.
module mem_stage_ctrl
   import mem_stage_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] BranchAddress_EX_MEM,
   input  logic [31:0] ALUResult_EX_MEM,
   input  logic [31:0] ReadData1_EX_MEM,
   input  logic [31:0] ReadData2_EX_MEM,
   input  logic [31:0] JumpAddress_EX_MEM,
   input  logic        BNE_EX_MEM,
   input  logic        BEQ_EX_MEM,
   input  logic        Zero_EX_MEM,
   input  logic        MemWrite_EX_MEM,
   input  logic        MemRead_EX_MEM,
   input  logic        JAL_EX_MEM,
   input  logic        J_EX_MEM,
   input  logic        JR_EX_MEM,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [1:0]  PCSel,
   output logic [31:0] NextPC,
   output logic        Flush_IF_ID,
   output logic        Flush_ID_EX,
   output logic        Flush_EX_MEM,
   output logic        Enable_PC,
   output logic        Enable_IF_ID,
   output logic        Enable_ID_EX,
   output logic        Enable_EX_MEM,
   output logic        Enable_MEM_WB,
   output logic        mem_timeout,
   output logic        illegal_ctrl,
   output logic [15:0] stall_count,
   output logic [1:0]  state_dbg
);

   // Handshake: mem_req stays high from the issue cycle until the falling
   // edge that samples mem_ready high; addr/data/we are stable meanwhile.

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_e      state, state_next;
   logic        taken, redirect;
   logic [1:0]  br_pc_sel;
   logic [31:0] br_next_pc;
   logic        run, access, issue;
   logic        req_we;
   logic [31:0] req_addr, req_wdata;
   logic        illegal_q;

   branch_resolve u_branch (
      .beq            (BEQ_EX_MEM),
      .bne            (BNE_EX_MEM),
      .zero           (Zero_EX_MEM),
      .j              (J_EX_MEM),
      .jal            (JAL_EX_MEM),
      .jr             (JR_EX_MEM),
      .branch_address (BranchAddress_EX_MEM),
      .jump_address   (JumpAddress_EX_MEM),
      .read_data1     (ReadData1_EX_MEM),
      .taken          (taken),
      .redirect       (redirect),
      .pc_sel         (br_pc_sel),
      .next_pc        (br_next_pc)
   );

   // Gating with reset keeps every output quiet while reset is held low.
   assign run    = reset & (state == ST_RUN);
   assign access = MemRead_EX_MEM | MemWrite_EX_MEM;
   assign issue  = run & access & ~redirect;

`ifdef MEM_TIMEOUT_EN
   logic [15:0] tmo_cnt;
   logic        tmo_hit;
   logic        mem_timeout_q;

   assign tmo_hit = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`endif

   always_ff @(negedge clk or negedge reset) begin
      if (!reset) state <= ST_RUN;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_RUN:      if (issue && !mem_ready) state_next = ST_MEM_WAIT;
`ifdef MEM_TIMEOUT_EN
         ST_MEM_WAIT: if (mem_ready)    state_next = ST_RUN;
                      else if (tmo_hit) state_next = ST_ABORT;
`else
         ST_MEM_WAIT: if (mem_ready) state_next = ST_RUN;
`endif
         ST_ABORT:    state_next = ST_RUN;
         default:     state_next = ST_RUN;
      endcase
   end

   always_comb begin
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = 32'd0;
      mem_wdata     = 32'd0;
      PCSel         = PCSEL_SEQ;
      NextPC        = 32'd0;
      Flush_IF_ID   = 1'b0;
      Flush_ID_EX   = 1'b0;
      Flush_EX_MEM  = 1'b0;
      Enable_PC     = 1'b1;
      Enable_IF_ID  = 1'b1;
      Enable_ID_EX  = 1'b1;
      Enable_EX_MEM = 1'b1;
      Enable_MEM_WB = 1'b1;
      if (reset) begin
         case (state)
            ST_RUN: begin
               PCSel        = br_pc_sel;
               NextPC       = br_next_pc;
               Flush_IF_ID  = redirect;
               Flush_ID_EX  = redirect;
               Flush_EX_MEM = redirect;
               if (issue) begin
                  mem_req   = 1'b1;
                  mem_we    = MemWrite_EX_MEM;
                  mem_addr  = ALUResult_EX_MEM;
                  mem_wdata = ReadData2_EX_MEM;
               end
            end
            ST_MEM_WAIT: begin
               mem_req       = 1'b1;
               mem_we        = req_we;
               mem_addr      = req_addr;
               mem_wdata     = req_wdata;
               Enable_PC     = 1'b0;
               Enable_IF_ID  = 1'b0;
               Enable_ID_EX  = 1'b0;
               Enable_EX_MEM = 1'b0;
               Enable_MEM_WB = 1'b0;
            end
            default: begin
               Enable_PC     = 1'b0;
               Enable_IF_ID  = 1'b0;
               Enable_ID_EX  = 1'b0;
               Enable_EX_MEM = 1'b0;
               Enable_MEM_WB = 1'b0;
            end
         endcase
      end
   end

   // Request registers, stall counter and sticky error flags.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         req_we      <= 1'b0;
         req_addr    <= 32'd0;
         req_wdata   <= 32'd0;
         stall_count <= 16'd0;
         illegal_q   <= 1'b0;
      end else begin
         if (issue && !mem_ready) begin
            req_we    <= MemWrite_EX_MEM;
            req_addr  <= ALUResult_EX_MEM;
            req_wdata <= ReadData2_EX_MEM;
         end
         if (state == ST_MEM_WAIT && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
         if (run && ((MemRead_EX_MEM & MemWrite_EX_MEM) | (access & redirect)))
            illegal_q <= 1'b1;
      end
   end

`ifdef MEM_TIMEOUT_EN
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         tmo_cnt       <= 16'd0;
         mem_timeout_q <= 1'b0;
      end else begin
         if (state == ST_MEM_WAIT && !mem_ready) tmo_cnt <= tmo_cnt + 16'd1;
         else                                    tmo_cnt <= 16'd0;
         if (state == ST_MEM_WAIT && state_next == ST_ABORT)
            mem_timeout_q <= 1'b1;
      end
   end

   assign mem_timeout = mem_timeout_q;
`else
   assign mem_timeout = 1'b0;
`endif

   assign illegal_ctrl = illegal_q;
   assign state_dbg    = state;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: a table of single-cycle RUN vectors
// followed by hand-written stall, reset, illegal and timeout sequences.
module tb_mem_stage_ctrl;
  import mem_stage_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] BranchAddress_EX_MEM, ALUResult_EX_MEM, ReadData1_EX_MEM;
  logic [31:0] ReadData2_EX_MEM, JumpAddress_EX_MEM;
  logic        BNE_EX_MEM, BEQ_EX_MEM, Zero_EX_MEM, MemWrite_EX_MEM, MemRead_EX_MEM;
  logic        JAL_EX_MEM, J_EX_MEM, JR_EX_MEM, mem_ready;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, NextPC;
  logic [1:0]  PCSel, state_dbg;
  logic        Flush_IF_ID, Flush_ID_EX, Flush_EX_MEM;
  logic        Enable_PC, Enable_IF_ID, Enable_ID_EX, Enable_EX_MEM, Enable_MEM_WB;
  logic        mem_timeout, illegal_ctrl;
  logic [15:0] stall_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  mem_stage_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .BranchAddress_EX_MEM(BranchAddress_EX_MEM), .ALUResult_EX_MEM(ALUResult_EX_MEM),
    .ReadData1_EX_MEM(ReadData1_EX_MEM), .ReadData2_EX_MEM(ReadData2_EX_MEM),
    .JumpAddress_EX_MEM(JumpAddress_EX_MEM),
    .BNE_EX_MEM(BNE_EX_MEM), .BEQ_EX_MEM(BEQ_EX_MEM), .Zero_EX_MEM(Zero_EX_MEM),
    .MemWrite_EX_MEM(MemWrite_EX_MEM), .MemRead_EX_MEM(MemRead_EX_MEM),
    .JAL_EX_MEM(JAL_EX_MEM), .J_EX_MEM(J_EX_MEM), .JR_EX_MEM(JR_EX_MEM),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .PCSel(PCSel), .NextPC(NextPC),
    .Flush_IF_ID(Flush_IF_ID), .Flush_ID_EX(Flush_ID_EX), .Flush_EX_MEM(Flush_EX_MEM),
    .Enable_PC(Enable_PC), .Enable_IF_ID(Enable_IF_ID), .Enable_ID_EX(Enable_ID_EX),
    .Enable_EX_MEM(Enable_EX_MEM), .Enable_MEM_WB(Enable_MEM_WB),
    .mem_timeout(mem_timeout), .illegal_ctrl(illegal_ctrl),
    .stall_count(stall_count), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic beq, bne, zero, j, jal, jr, mrd, mwr, rdy;
    logic [31:0] br, alu, rd1, rd2, jaddr;
    logic [1:0]  exp_pcsel;
    logic [31:0] exp_npc;
    logic exp_flush, exp_req, exp_we;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    {BEQ_EX_MEM, BNE_EX_MEM, Zero_EX_MEM, J_EX_MEM, JAL_EX_MEM, JR_EX_MEM} = '0;
    {MemRead_EX_MEM, MemWrite_EX_MEM} = '0;
    mem_ready = 1'b1;
    BranchAddress_EX_MEM = 32'd0; ALUResult_EX_MEM = 32'd0; ReadData1_EX_MEM = 32'd0;
    ReadData2_EX_MEM = 32'd0; JumpAddress_EX_MEM = 32'd0;
  endtask

  task automatic apply(input vec_t v);
    BEQ_EX_MEM = v.beq; BNE_EX_MEM = v.bne; Zero_EX_MEM = v.zero;
    J_EX_MEM = v.j; JAL_EX_MEM = v.jal; JR_EX_MEM = v.jr;
    MemRead_EX_MEM = v.mrd; MemWrite_EX_MEM = v.mwr; mem_ready = v.rdy;
    BranchAddress_EX_MEM = v.br; ALUResult_EX_MEM = v.alu; ReadData1_EX_MEM = v.rd1;
    ReadData2_EX_MEM = v.rd2; JumpAddress_EX_MEM = v.jaddr;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  function automatic logic [31:0] enables();
    return {27'd0, Enable_PC, Enable_IF_ID, Enable_ID_EX, Enable_EX_MEM, Enable_MEM_WB};
  endfunction

  function automatic logic [31:0] flushes();
    return {29'd0, Flush_IF_ID, Flush_ID_EX, Flush_EX_MEM};
  endfunction

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    // fields: beq bne zero j jal jr mrd mwr rdy | br alu rd1 rd2 jaddr | pcsel npc flush req we
    vecs[0] = '{1,0,1,0,0,0,0,0,1, 32'h0040_0020, 0, 0, 0, 0,           2'd1, 32'h0040_0020, 1,0,0};
    vecs[1] = '{0,1,1,0,0,0,0,0,1, 32'h0040_0030, 0, 0, 0, 0,           2'd0, 32'h0,         0,0,0};
    vecs[2] = '{0,1,0,0,0,0,0,0,1, 32'h0040_0044, 0, 0, 0, 0,           2'd1, 32'h0040_0044, 1,0,0};
    vecs[3] = '{0,0,0,1,0,1,0,0,1, 0, 0, 32'h0040_0100, 0, 32'h0040_0200, 2'd3, 32'h0040_0100, 1,0,0};
    vecs[4] = '{0,0,0,0,1,0,0,0,1, 0, 0, 0, 0, 32'h0040_0300,           2'd2, 32'h0040_0300, 1,0,0};
    vecs[5] = '{0,0,0,1,0,0,0,0,1, 0, 0, 0, 0, 32'h0040_0400,           2'd2, 32'h0040_0400, 1,0,0};
    vecs[6] = '{0,0,0,0,0,0,1,0,1, 0, 32'h1001_0008, 0, 32'h1234_5678, 0, 2'd0, 32'h0,         0,1,0};
    vecs[7] = '{0,0,0,0,0,0,0,1,1, 0, 32'h1001_000C, 0, 32'hCAFE_0001, 0, 2'd0, 32'h0,         0,1,1};
    vecs[8] = '{0,0,0,0,0,0,0,0,1, 0, 0, 0, 0, 0,                       2'd0, 32'h0,         0,0,0};
    vecs[9] = '{1,0,0,0,0,0,0,0,1, 32'h0040_0050, 0, 0, 0, 0,           2'd0, 32'h0,         0,0,0};

    // reset state, with live inputs that would otherwise redirect and request
    reset = 1'b0;
    idle_inputs();
    BEQ_EX_MEM = 1'b1; Zero_EX_MEM = 1'b1; MemRead_EX_MEM = 1'b1;
    #3;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_flush", flushes(), 32'd0);
    chk("rst_pcsel", 32'(PCSel), 32'd0);
    chk("rst_enables", enables(), 32'h1F);
    chk("rst_stall_count", 32'(stall_count), 32'd0);
    chk("rst_illegal", 32'(illegal_ctrl), 32'd0);
    chk("rst_timeout", 32'(mem_timeout), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(ST_RUN));
    idle_inputs();
    #10;
    reset = 1'b1;
    tick();

    // table of single-cycle RUN vectors
    for (int i = 0; i < 10; i++) begin
      apply(vecs[i]);
      #2;
      chk($sformatf("v%0d_pcsel", i), 32'(PCSel), 32'(vecs[i].exp_pcsel));
      chk($sformatf("v%0d_nextpc", i), NextPC, vecs[i].exp_npc);
      chk($sformatf("v%0d_flush", i), flushes(), vecs[i].exp_flush ? 32'h7 : 32'h0);
      chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(vecs[i].exp_req));
      chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].exp_we));
      chk($sformatf("v%0d_enables", i), enables(), 32'h1F);
      if (vecs[i].exp_req) begin
        chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].alu);
        chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].rd2);
      end
      tick();
      chk($sformatf("v%0d_state", i), 32'(state_dbg), 32'(ST_RUN));
    end
    idle_inputs();
    #2;
    chk("table_illegal", 32'(illegal_ctrl), 32'd0);
    chk("table_stall_count", 32'(stall_count), 32'd0);
    tick();

    // write with mem_ready low for three cycles
    MemWrite_EX_MEM = 1'b1; ALUResult_EX_MEM = 32'h1001_0004;
    ReadData2_EX_MEM = 32'hDEAD_BEEF; mem_ready = 1'b0;
    exp_q.push_back(32'h1001_0004);
    exp_q.push_back(32'hDEAD_BEEF);
    #2;
    chk("wr_issue_req", 32'(mem_req), 32'd1);
    chk("wr_issue_we", 32'(mem_we), 32'd1);
    chk("wr_issue_addr", mem_addr, exp_q[0]);
    tick();
    idle_inputs();
    ALUResult_EX_MEM = 32'h5555_5555; ReadData2_EX_MEM = 32'hAAAA_AAAA;
    for (int k = 0; k < 3; k++) begin
      mem_ready = (k == 2);
      #2;
      chk($sformatf("wait%0d_state", k), 32'(state_dbg), 32'(ST_MEM_WAIT));
      chk($sformatf("wait%0d_req", k), 32'(mem_req), 32'd1);
      chk($sformatf("wait%0d_we", k), 32'(mem_we), 32'd1);
      chk($sformatf("wait%0d_addr", k), mem_addr, exp_q[0]);
      chk($sformatf("wait%0d_wdata", k), mem_wdata, exp_q[1]);
      chk($sformatf("wait%0d_enables", k), enables(), 32'h0);
      chk($sformatf("wait%0d_flush", k), flushes(), 32'h0);
      tick();
    end
    exp_q.delete();
    idle_inputs();
    #2;
    chk("resume_state", 32'(state_dbg), 32'(ST_RUN));
    chk("resume_enables", enables(), 32'h1F);
    chk("resume_req", 32'(mem_req), 32'd0);
    chk("stall_count_3", 32'(stall_count), 32'd3);
    tick();

    // redirect suppressed while waiting
    MemRead_EX_MEM = 1'b1; mem_ready = 1'b0; ALUResult_EX_MEM = 32'h1001_0010;
    tick();
    MemRead_EX_MEM = 1'b0; BEQ_EX_MEM = 1'b1; Zero_EX_MEM = 1'b1;
    BranchAddress_EX_MEM = 32'h0040_0080;
    #2;
    chk("wait_no_flush", flushes(), 32'h0);
    chk("wait_pcsel", 32'(PCSel), 32'd0);

    // reset pulsed mid-wait abandons the access
    tick();
    idle_inputs();
    mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("rstwait_req", 32'(mem_req), 32'd0);
    chk("rstwait_state", 32'(state_dbg), 32'(ST_RUN));
    chk("rstwait_stall_count", 32'(stall_count), 32'd0);
    chk("rstwait_enables", enables(), 32'h1F);
    #1;
    reset = 1'b1;
    tick();
    #2;
    chk("after_rst_req", 32'(mem_req), 32'd0);
    chk("after_rst_state", 32'(state_dbg), 32'(ST_RUN));
    tick();

    // read coinciding with a jump: redirect wins, illegal_ctrl set
    idle_inputs();
    pulse_reset();
    tick();
    MemRead_EX_MEM = 1'b1; J_EX_MEM = 1'b1; JumpAddress_EX_MEM = 32'h0040_0500;
    ALUResult_EX_MEM = 32'h1001_0020;
    #2;
    chk("rdj_pcsel", 32'(PCSel), 32'd2);
    chk("rdj_nextpc", NextPC, 32'h0040_0500);
    chk("rdj_req", 32'(mem_req), 32'd0);
    chk("rdj_flush", flushes(), 32'h7);
    chk("rdj_illegal_pre", 32'(illegal_ctrl), 32'd0);
    tick();
    idle_inputs();
    #2;
    chk("rdj_illegal", 32'(illegal_ctrl), 32'd1);
    chk("rdj_state", 32'(state_dbg), 32'(ST_RUN));
    tick();

    // read and write together: treated as a write, illegal_ctrl set
    pulse_reset();
    #1;
    chk("rw_illegal_cleared", 32'(illegal_ctrl), 32'd0);
    tick();
    MemRead_EX_MEM = 1'b1; MemWrite_EX_MEM = 1'b1; ALUResult_EX_MEM = 32'h1001_0030;
    #2;
    chk("rw_req", 32'(mem_req), 32'd1);
    chk("rw_we", 32'(mem_we), 32'd1);
    tick();
    idle_inputs();
    #2;
    chk("rw_illegal", 32'(illegal_ctrl), 32'd1);
    tick();

    // read that never sees mem_ready
    pulse_reset();
    tick();
    MemRead_EX_MEM = 1'b1; ALUResult_EX_MEM = 32'h1001_0040; mem_ready = 1'b0;
    #2;
    chk("tmo_issue_req", 32'(mem_req), 32'd1);
    tick();
    MemRead_EX_MEM = 1'b0;
`ifdef MEM_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      #2;
      chk($sformatf("tmo_wait%0d_state", k), 32'(state_dbg), 32'(ST_MEM_WAIT));
      chk($sformatf("tmo_wait%0d_flag", k), 32'(mem_timeout), 32'd0);
      tick();
    end
    #2;
    chk("abort_state", 32'(state_dbg), 32'(ST_ABORT));
    chk("abort_timeout", 32'(mem_timeout), 32'd1);
    chk("abort_req", 32'(mem_req), 32'd0);
    chk("abort_enables", enables(), 32'h0);
    tick();
    #2;
    chk("post_abort_state", 32'(state_dbg), 32'(ST_RUN));
    chk("post_abort_timeout", 32'(mem_timeout), 32'd1);
    chk("post_abort_enables", enables(), 32'h1F);
`else
    for (int k = 0; k < 20; k++) begin
      #2;
      chk($sformatf("hold_wait%0d_state", k), 32'(state_dbg), 32'(ST_MEM_WAIT));
      chk($sformatf("hold_wait%0d_flag", k), 32'(mem_timeout), 32'd0);
      tick();
    end
    mem_ready = 1'b1;
    tick();
    #2;
    chk("hold_exit_state", 32'(state_dbg), 32'(ST_RUN));
    chk("hold_stall_count", 32'(stall_count), 32'd21);
`endif
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
